// File: rtl/pdm_rx_iom.sv
// pdm_rx_iom: PDM microphone receiver with an IO-bus register interface and a sample FIFO.
// Build option PDM_RX_SIGNED_EN: push samples as signed 2*count-DECIM instead of the raw ones count.
module pdm_rx_iom #(
    parameter int CLK_DIV    = 4,
    parameter int DECIM      = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [11:0] io_address,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic        pdm_clk,
    input  logic        pdm_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV + 1);

    logic              enable;
    logic              overflow;
    logic [DW-1:0]     div_cnt;
    logic              sync1;
    logic              sync2;
    logic [15:0]       acc;
    logic [7:0]        bit_cnt;
    logic [15:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic [1:0]        reg_sel;
    logic              take;
    logic [15:0]       acc_next;
    logic              push;
    logic [15:0]       sample;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push_ok;
    logic              push_fail;
    logic              flush;
    logic              ctrl_wr;
    logic              ovf_clr;
    logic [31:0]       status;
    logic [31:0]       head;
    logic [31:0]       rdata;

    logic unused_bits;
    assign unused_bits = ^{io_addr_strobe, io_address[11:4], io_address[1:0],
                           io_byte_enable[3:1], io_write_data[31:3]};

    always_comb begin
        reg_sel    = io_address[3:2];
        take       = enable && (div_cnt == DW'(CLK_DIV - 1)) && pdm_clk;
        acc_next   = acc + 16'(sync2);
        push       = take && (bit_cnt == 8'(DECIM - 1));
`ifdef PDM_RX_SIGNED_EN
        sample     = (acc_next << 1) - 16'(DECIM);
        head       = {{16{mem[rd_ptr][15]}}, mem[rd_ptr]};
`else
        sample     = acc_next;
        head       = {16'h0000, mem[rd_ptr]};
`endif
        fifo_empty = (count == '0);
        fifo_full  = (count == (AW + 1)'(FIFO_DEPTH));
        pop        = io_read_strobe && (reg_sel == 2'd2) && !fifo_empty;
        ctrl_wr    = io_write_strobe && (reg_sel == 2'd0) && io_byte_enable[0];
        flush      = ctrl_wr && io_write_data[1];
        ovf_clr    = io_write_strobe && (reg_sel == 2'd1) && io_byte_enable[0] && io_write_data[2];
        // Flush wins over a same-cycle push; a push into a full FIFO fits only if a pop frees a slot
        push_ok    = push && !flush && (!fifo_full || pop);
        push_fail  = push && !flush && fifo_full && !pop;
        status     = {16'h0000, 8'(count), 5'b00000, overflow, fifo_full, fifo_empty};
        case (reg_sel)
            2'd0:    rdata = {31'b0, enable};
            2'd1:    rdata = status;
            2'd2:    rdata = fifo_empty ? '0 : head;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_ready     <= 1'b0;
            io_read_data <= '0;
            enable       <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            io_ready     <= io_read_strobe | io_write_strobe;
            io_read_data <= io_read_strobe ? rdata : '0;
            if (ctrl_wr)
                enable <= io_write_data[0];
            if (push_fail)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            pdm_clk <= ~pdm_clk;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pdm_data;
            sync2 <= sync1;
        end
    end

    // Disabling discards a partial window so the next sample starts on fresh bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (!enable || push) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (take) begin
            acc     <= acc_next;
            bit_cnt <= bit_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= sample;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_rx_iom.sv
// tb_pdm_rx_iom: directed bench for pdm_rx_iom with a cycle-level behavioural model of the register map.
// Honours PDM_RX_SIGNED_EN for the expected sample encoding.
module tb_pdm_rx_iom;

    localparam int CD  = 2;
    localparam int DEC = 8;
    localparam int FD  = 4;

    localparam logic [31:0] E_ONE = 32'h0000_0008;
`ifdef PDM_RX_SIGNED_EN
    localparam logic [31:0] E_ALT  = 32'h0000_0000;
    localparam logic [31:0] E_ZERO = 32'hFFFF_FFF8;
`else
    localparam logic [31:0] E_ALT  = 32'h0000_0004;
    localparam logic [31:0] E_ZERO = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        io_addr_strobe = 1'b0;
    logic        io_read_strobe = 1'b0;
    logic        io_write_strobe = 1'b0;
    logic [11:0] io_address = '0;
    logic [3:0]  io_byte_enable = '0;
    logic [31:0] io_write_data = '0;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic        pdm_clk;
    logic        pdm_data = 1'b0;

    pdm_rx_iom #(.CLK_DIV(CD), .DECIM(DEC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address),
        .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .pdm_clk(pdm_clk), .pdm_data(pdm_data)
    );

    always #5 clk = ~clk;

    // Behavioural model: register map, FIFO as a queue, pdm_clk from cycles-since-enable
    int          m_n, m_ones, m_bits, m_sz, m_v;
    bit          m_en, m_ovf, h1, h2;
    bit          m_pop, m_push, m_flush;
    logic [15:0] m_val;
    logic [31:0] m_rd;
    logic [15:0] fq[$];
    bit          exp_ready, exp_pdm;
    logic [31:0] exp_rdata;

    function automatic logic [31:0] ext(logic [15:0] v);
`ifdef PDM_RX_SIGNED_EN
        return {{16{v[15]}}, v};
`else
        return {16'h0000, v};
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_ones = 0; m_bits = 0; m_en = 0; m_ovf = 0; h1 = 0; h2 = 0;
            fq.delete();
            exp_ready = 0; exp_pdm = 0; exp_rdata = '0;
        end else begin
            m_sz = fq.size(); m_rd = '0; m_pop = 0; m_push = 0; m_val = '0;
            m_flush = io_write_strobe && io_address[3:2] == 2'd0 && io_byte_enable[0] && io_write_data[1];
            if (io_read_strobe) begin
                case (io_address[3:2])
                    2'd0: m_rd = {31'b0, m_en};
                    2'd1: m_rd = {16'h0000, 8'(m_sz), 5'b0, m_ovf, m_sz == FD, m_sz == 0};
                    2'd2: if (m_sz > 0) begin m_rd = ext(fq[0]); m_pop = 1; end
                    default: m_rd = '0;
                endcase
            end
            exp_ready = io_read_strobe | io_write_strobe;
            exp_rdata = m_rd;
            if (m_en) begin
                m_n++;
                if (m_n % (2 * CD) == 0) begin
                    m_ones += int'(h2);
                    m_bits++;
                    if (m_bits == DEC) begin
                        m_push = 1;
`ifdef PDM_RX_SIGNED_EN
                        m_v = 2 * m_ones - DEC;
`else
                        m_v = m_ones;
`endif
                        m_val = 16'(m_v);
                        m_ones = 0; m_bits = 0;
                    end
                end
                exp_pdm = ((m_n / CD) % 2 == 1);
            end else begin
                m_n = 0; m_ones = 0; m_bits = 0; exp_pdm = 0;
            end
            h2 = h1; h1 = pdm_data;
            if (io_write_strobe && io_address[3:2] == 2'd1 && io_byte_enable[0] && io_write_data[2])
                m_ovf = 0;
            if (m_flush) fq.delete();
            else begin
                if (m_pop) void'(fq.pop_front());
                if (m_push) begin
                    if (fq.size() < FD) fq.push_back(m_val);
                    else m_ovf = 1;
                end
            end
            if (io_write_strobe && io_address[3:2] == 2'd0 && io_byte_enable[0])
                m_en = io_write_data[0];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int pmode = 1;      // 0: const 0, 1: const 1, 2: toggle once per pdm_clk period
    logic prev_pclk = 1'b0;
    logic [31:0] rv;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        n_cmp++;
        if (io_ready !== exp_ready || io_read_data !== exp_rdata || pdm_clk !== exp_pdm) begin
            n_bad++;
            $display("FAIL model t=%0t ready=%b/%b rdata=%h/%h pdm_clk=%b/%b", $time,
                     io_ready, exp_ready, io_read_data, exp_rdata, pdm_clk, exp_pdm);
        end
        if (pmode == 2 && pdm_clk && !prev_pclk) pdm_data = ~pdm_data;
        else if (pmode == 1) pdm_data = 1'b1;
        else if (pmode == 0) pdm_data = 1'b0;
        prev_pclk = pdm_clk;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        io_address = a; io_write_data = d; io_byte_enable = be;
        io_write_strobe = 1'b1; io_addr_strobe = 1'b1;
        tick();
        io_write_strobe = 1'b0; io_addr_strobe = 1'b0;
        check("wr_ready", {31'b0, io_ready}, 32'd1);
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        io_address = a; io_read_strobe = 1'b1; io_addr_strobe = 1'b1;
        tick();
        io_read_strobe = 1'b0; io_addr_strobe = 1'b0;
        check("rd_ready", {31'b0, io_ready}, 32'd1);
        d = io_read_data;
    endtask

    task automatic check_reset_regs(input string tag);
        bus_read(12'h000, rv); check({tag, "_ctrl"}, rv, 32'h0);
        bus_read(12'h004, rv); check({tag, "_status"}, rv, 32'h1);
        bus_read(12'h008, rv); check({tag, "_data"}, rv, 32'h0);
        bus_read(12'h00C, rv); check({tag, "_rsvd"}, rv, 32'h0);
    endtask

    task automatic one_window(input int mode, input logic [31:0] want, input string name);
        pmode = mode;
        wait_cycles(4);
        bus_write(12'h000, 32'h1, 4'h1);
        wait_cycles(36);
        bus_write(12'h000, 32'h0, 4'h1);
        bus_read(12'h004, rv); check({name, "_status"}, rv, 32'h0000_0100);
        bus_read(12'h008, rv); check({name, "_data"}, rv, want);
    endtask

    initial begin
        #1 rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        tick();
        check_reset_regs("por");
        check("por_pdm_clk", {31'b0, pdm_clk}, 32'd0);

        one_window(1, E_ONE, "ones");
        one_window(2, E_ALT, "alt");
        one_window(0, E_ZERO, "zeros");

        // five windows, only four fit
        pmode = 1;
        bus_write(12'h000, 32'h1, 4'h1);
        wait_cycles(164);
        bus_write(12'h000, 32'h0, 4'h1);
        bus_read(12'h004, rv); check("ovf_status", rv, 32'h0000_0406);
        for (int i = 0; i < 4; i++) begin
            bus_read(12'h008, rv); check("ovf_data", rv, E_ONE);
        end
        bus_read(12'h008, rv); check("ovf_data_empty", rv, 32'h0);
        bus_write(12'h004, 32'h4, 4'h0);
        bus_read(12'h004, rv); check("ovf_w1c_noBE", rv, 32'h0000_0005);
        bus_write(12'h004, 32'h4, 4'h1);
        bus_read(12'h004, rv); check("ovf_w1c", rv, 32'h0000_0001);

        // flush with two queued samples, then mid-window disable
        bus_write(12'h000, 32'h1, 4'h1);
        wait_cycles(68);
        bus_write(12'h000, 32'h0, 4'h1);
        bus_read(12'h004, rv); check("fl_status_pre", rv, 32'h0000_0200);
        bus_write(12'h000, 32'h3, 4'h1);
        bus_read(12'h004, rv); check("fl_status", rv, 32'h0000_0001);
        bus_read(12'h000, rv); check("fl_ctrl", rv, 32'h0000_0001);
        wait_cycles(14);
        bus_write(12'h000, 32'h0, 4'h1);
        one_window(0, E_ZERO, "fresh");

        // reset during a window and during a pending read
        pmode = 1;
        bus_write(12'h000, 32'h1, 4'h1);
        wait_cycles(40);
        io_address = 12'h008; io_read_strobe = 1'b1; io_addr_strobe = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        io_read_strobe = 1'b0; io_addr_strobe = 1'b0;
        #1;
        check("rst_ready", {31'b0, io_ready}, 32'd0);
        check("rst_rdata", io_read_data, 32'd0);
        check("rst_pdm_clk", {31'b0, pdm_clk}, 32'd0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(4);
        check_reset_regs("rst");
        wait_cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pdm_rx_iom.md
PDM_RX_IOM -- requirements
Module: pdm_rx_iom

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per pdm_clk half-period (>=1).
REQ-002 SHALL have parameter DECIM, default 64: PDM bits per output sample (2..255).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: sample FIFO entries (power of 2, 2..128).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports io_addr_strobe, io_read_strobe, io_write_strobe  input  1 each  IO bus strobes, one-cycle pulses.
REQ-007 SHALL have port io_address  input  12  byte address; only [3:2] decoded, [11:4] and [1:0] ignored.
REQ-008 SHALL have port io_byte_enable  input  4  write byte lanes.
REQ-009 SHALL have port io_write_data  input  32  write data.
REQ-010 SHALL have port io_read_data  output  32  read data, valid while io_ready high.
REQ-011 SHALL have port io_ready  output  1  one-cycle transfer completion.
REQ-012 SHALL have port pdm_clk  output  1  clock to PDM microphone.
REQ-013 SHALL have port pdm_data  input  1  asynchronous PDM bitstream from microphone.

Function
REQ-014 Register map SHALL be: 0x0 CTRL (RW), 0x4 STATUS (RW), 0x8 DATA (RO), 0xC reserved (reads 0, writes ignored).
REQ-015 CTRL SHALL be: [0] enable (RW); [1] flush (write-1 action, reads 0); other bits read 0; write takes effect only if io_byte_enable[0].
REQ-016 STATUS SHALL be: [0] empty, [1] full, [2] overflow (sticky, write-1-to-clear with io_byte_enable[0]), [15:8] FIFO count; others 0.
REQ-017 Each read or write strobe SHALL produce io_ready exactly one cycle later for one cycle; io_read_data SHALL equal the register value that cycle and 0 otherwise.
REQ-018 DATA read with FIFO non-empty SHALL return the oldest sample (zero-extended to 32 bits) and pop it; DATA read when empty SHALL return 0 and not pop.
REQ-019 While enable=1, pdm_clk SHALL toggle every CLK_DIV clk cycles (period 2*CLK_DIV); while enable=0, pdm_clk SHALL be held low and its divider counter cleared.
REQ-020 pdm_data SHALL pass a 2-flop synchronizer; one bit SHALL be taken from the synchronizer output in the clk cycle where pdm_clk is driven high->low.
REQ-021 An accumulator SHALL count ones among taken bits; after the DECIM-th bit the count (0..DECIM, 16-bit) SHALL be pushed to the FIFO and accumulator and bit counter cleared in the same cycle.
REQ-022 Push with FIFO full SHALL discard the sample and set overflow; FIFO contents unchanged.
REQ-023 Simultaneous push and pop SHALL both succeed, including when full (no overflow) and when empty-with-pop-ignored (push only).
REQ-024 Clearing enable SHALL clear accumulator and bit counter (partial window discarded); FIFO and overflow retained.
REQ-025 Flush SHALL empty the FIFO in the write cycle and take priority over a same-cycle push; overflow unaffected.

Reset
REQ-026 rst SHALL asynchronously clear: enable, overflow, FIFO pointers/count, accumulator, bit counter, divider, synchronizer; io_ready=0, io_read_data=0, pdm_clk=0.
REQ-027 rst asserted mid-transfer SHALL suppress the pending io_ready; after release the block SHALL respond only to new strobes.

Configuration
REQ-028 Macro PDM_RX_SIGNED_EN defined: pushed sample SHALL be 2*count-DECIM as 16-bit two's complement, DATA sign-extended to 32 bits.
REQ-029 Macro PDM_RX_SIGNED_EN undefined: pushed sample SHALL be the unsigned count, zero-extended.

Verification (bench: CLK_DIV=2, DECIM=8, FIFO_DEPTH=4)
REQ-030 Post-reset reads of 0x0/0x4/0x8/0xC -> 0x0, 0x1, 0x0, 0x0; io_ready one cycle after each strobe; pdm_clk low.
REQ-031 Write CTRL=1, pdm_data=1 constant, wait one window (32 clk + sync) -> STATUS count 1; DATA=8 (signed build: 8); pdm_clk period 4 clk.
REQ-032 pdm_data alternating per pdm_clk period -> DATA=4 (signed build: 0); pdm_data=0 -> DATA=0 (signed: 0xFFFFFFF8).
REQ-033 Enable for 5 windows without reading -> STATUS=0x0406 (count 4, full, overflow); 4 DATA reads return first 4 samples; 5th returns 0; write STATUS=0x4 -> overflow clear.
REQ-034 Write CTRL=0x3 with FIFO holding 2 -> STATUS count 0, empty; CTRL reads 0x1; disable mid-window then re-enable -> next sample covers full 8 fresh bits.
REQ-035 Assert rst mid-window and mid-read -> no io_ready, all registers back to REQ-030 values, pdm_clk low immediately.
